// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two masters.
// One access at a time through an IDLE -> ACCESS -> DONE sequencer; bad addresses never reach memory.
module data_memory_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0,
  input  logic        I_req1,
  input  logic        I_we0,
  input  logic        I_we1,
  input  logic [31:0] I_addr0,
  input  logic [31:0] I_addr1,
  input  logic [31:0] I_wdata0,
  input  logic [31:0] I_wdata1,
  output logic        O_ack0,
  output logic        O_ack1,
  output logic        O_err0,
  output logic        O_err1,
  output logic [31:0] O_rdata0,
  output logic [31:0] O_rdata1,
  output logic        O_mem_memrw,
  output logic [31:0] O_mem_address,
  output logic [31:0] O_mem_data,
  input  logic [31:0] I_mem_data,
  output logic        O_busy
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_BYTES - 32'd4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic          port_q,  port_d;
  logic          we_q,    we_d;
  logic          err_q,   err_d;
  logic          last_q,  last_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          busy_q, busy_d;

  logic          any_req_c;
  logic          gnt_port_c;
  logic          gnt_we_c;
  logic [AW-1:0] gnt_addr_c;
  logic [AW-1:0] gnt_wdata_c;
  logic          gnt_err_c;

  // Grant selection: on a tie the port opposite the last grant wins
  always_comb begin
    any_req_c   = I_req0 | I_req1;
    gnt_port_c  = (I_req0 & I_req1) ? ~last_q : I_req1;
    gnt_we_c    = gnt_port_c ? I_we1    : I_we0;
    gnt_addr_c  = gnt_port_c ? I_addr1  : I_addr0;
    gnt_wdata_c = gnt_port_c ? I_wdata1 : I_wdata0;
    gnt_err_c   = (gnt_addr_c[1:0] != 2'b00) || (gnt_addr_c > MAX_ADDR);
  end

  // State register
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req_c) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    port_d   = port_q;
    we_d     = we_q;
    err_d    = err_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          port_d  = gnt_port_c;
          we_d    = gnt_we_c;
          addr_d  = gnt_addr_c;
          wdata_d = gnt_wdata_c;
          err_d   = gnt_err_c;
          last_d  = gnt_port_c;
        end
      end
      ST_ACCESS: begin
        // Completion is registered here so ack/err appear throughout DONE
        if (port_q) begin
          ack1_d = 1'b1;
          err1_d = err_q;
          if (!we_q) rdata1_d = err_q ? 32'd0 : I_mem_data;
        end else begin
          ack0_d = 1'b1;
          err0_d = err_q;
          if (!we_q) rdata0_d = err_q ? 32'd0 : I_mem_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      port_q   <= port_d;
      we_q     <= we_d;
      err_q    <= err_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      busy_q   <= busy_d;
    end
  end

  // Write enable gated by reset so a store interrupted in ACCESS never commits
  assign O_mem_memrw   = (state_q == ST_ACCESS) & we_q & ~err_q & ~I_reset;
  assign O_mem_address = addr_q;
  assign O_mem_data    = wdata_q;
  assign O_ack0        = ack0_q;
  assign O_ack1        = ack1_q;
  assign O_err0        = err0_q;
  assign O_err1        = err1_q;
  assign O_rdata0      = rdata0_q;
  assign O_rdata1      = rdata1_q;
  assign O_busy        = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural single-port memory.
module tb_data_memory_arbiter;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_req0, I_req1, I_we0, I_we1;
  logic [31:0] I_addr0, I_addr1, I_wdata0, I_wdata1;
  logic        O_ack0, O_ack1, O_err0, O_err1;
  logic [31:0] O_rdata0, O_rdata1;
  logic        O_mem_memrw;
  logic [31:0] O_mem_address, O_mem_data, I_mem_data;
  logic        O_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  always #5 I_clk = ~I_clk;

  always @(posedge I_clk) if (O_mem_memrw) mem[O_mem_address[9:2]] <= O_mem_data;
  assign I_mem_data = mem[O_mem_address[9:2]];

  data_memory_arbiter #(.MEM_BYTES(1024)) dut (
    .I_clk(I_clk), .I_reset(I_reset),
    .I_req0(I_req0), .I_req1(I_req1), .I_we0(I_we0), .I_we1(I_we1),
    .I_addr0(I_addr0), .I_addr1(I_addr1), .I_wdata0(I_wdata0), .I_wdata1(I_wdata1),
    .O_ack0(O_ack0), .O_ack1(O_ack1), .O_err0(O_err0), .O_err1(O_err1),
    .O_rdata0(O_rdata0), .O_rdata1(O_rdata1),
    .O_mem_memrw(O_mem_memrw), .O_mem_address(O_mem_address), .O_mem_data(O_mem_data),
    .I_mem_data(I_mem_data), .O_busy(O_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack0", 32'(O_ack0), 32'd0);
    chk("rst_ack1", 32'(O_ack1), 32'd0);
    chk("rst_err0", 32'(O_err0), 32'd0);
    chk("rst_err1", 32'(O_err1), 32'd0);
    chk("rst_rdata0", O_rdata0, 32'd0);
    chk("rst_rdata1", O_rdata1, 32'd0);
    chk("rst_memrw", 32'(O_mem_memrw), 32'd0);
    chk("rst_mem_addr", O_mem_address, 32'd0);
    chk("rst_mem_data", O_mem_data, 32'd0);
    chk("rst_busy", 32'(O_busy), 32'd0);
  endtask

  task automatic apply_reset();
    I_reset = 1'b1;
    step();
    step();
    check_reset_outputs();
    I_reset = 1'b0;
  endtask

  // One isolated transaction starting in an IDLE cycle; returns in the following IDLE cycle
  task automatic txn(input bit p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic e, input logic [31:0] exp_rd);
    if (p) begin
      I_req1 = 1'b1; I_we1 = we; I_addr1 = a; I_wdata1 = wd;
    end else begin
      I_req0 = 1'b1; I_we0 = we; I_addr0 = a; I_wdata0 = wd;
    end
    step();
    chk("acc_busy", 32'(O_busy), 32'd1);
    chk("acc_memrw", 32'(O_mem_memrw), 32'(we & ~e));
    chk("acc_mem_addr", O_mem_address, a);
    chk("acc_ack_early", 32'(O_ack0 | O_ack1), 32'd0);
    if (we && !e) chk("acc_mem_data", O_mem_data, wd);
    step();
    chk("done_ack", 32'(p ? O_ack1 : O_ack0), 32'd1);
    chk("done_ack_other", 32'(p ? O_ack0 : O_ack1), 32'd0);
    chk("done_err", 32'(p ? O_err1 : O_err0), 32'(e));
    chk("done_rdata", p ? O_rdata1 : O_rdata0, exp_rd);
    chk("done_memrw", 32'(O_mem_memrw), 32'd0);
    I_req0 = 1'b0;
    I_req1 = 1'b0;
    step();
    chk("idle_ack", 32'(O_ack0 | O_ack1), 32'd0);
    chk("idle_busy", 32'(O_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    I_reset = 1'b1;
    I_req0 = 1'b0; I_req1 = 1'b0; I_we0 = 1'b0; I_we1 = 1'b0;
    I_addr0 = '0; I_addr1 = '0; I_wdata0 = '0; I_wdata1 = '0;

    apply_reset();

    // Single store then load on port 0; a store leaves rdata0 untouched
    txn(1'b0, 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Continuous contention from fresh reset: grants 0,1,0,1
    apply_reset();
    I_req0 = 1'b1; I_we0 = 1'b0; I_addr0 = 32'h000; I_wdata0 = 32'h0;
    I_req1 = 1'b1; I_we1 = 1'b1; I_addr1 = 32'h004; I_wdata1 = 32'h1122_3344;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("cont_ack0_c%0d", c), 32'(O_ack0), 32'((c == 2) || (c == 8)));
      chk($sformatf("cont_ack1_c%0d", c), 32'(O_ack1), 32'((c == 5) || (c == 11)));
      chk($sformatf("cont_memrw_c%0d", c), 32'(O_mem_memrw), 32'((c == 4) || (c == 10)));
      if (c == 2 || c == 8) chk($sformatf("cont_rdata0_c%0d", c), O_rdata0, 32'hA000_0000);
      if (c == 11) begin
        I_req0 = 1'b0;
        I_req1 = 1'b0;
      end
    end

    // Misaligned store rejected; memory keeps the earlier value
    txn(1'b1, 1'b1, 32'h006, 32'hAAAA_AAAA, 1'b1, 32'h0);
    txn(1'b1, 1'b0, 32'h004, 32'h0, 1'b0, 32'h1122_3344);

    // Out-of-range boundary
    txn(1'b0, 1'b0, 32'h3FD, 32'h0, 1'b1, 32'h0);
    txn(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA000_00FF);
    txn(1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
    txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);

    // Reset during the ACCESS cycle of a store
    I_req0 = 1'b1; I_we0 = 1'b1; I_addr0 = 32'h020; I_wdata0 = 32'h55AA_55AA;
    step();
    chk("mid_memrw_before", 32'(O_mem_memrw), 32'd1);
    I_reset = 1'b1;
    #1;
    chk("mid_memrw_gated", 32'(O_mem_memrw), 32'd0);
    I_req0 = 1'b0;
    step();
    check_reset_outputs();
    I_reset = 1'b0;
    txn(1'b0, 1'b0, 32'h020, 32'h0, 1'b0, 32'hA000_0008);

    // Quiet period
    for (int c = 0; c < 20; c++) begin
      step();
      chk("quiet_busy", 32'(O_busy), 32'd0);
      chk("quiet_memrw", 32'(O_mem_memrw), 32'd0);
      chk("quiet_ack", 32'(O_ack0 | O_ack1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port, word-wide data memory between the CPU load/store path (port 0) and a second master (port 1: debug or DMA). Requests are handled one at a time through a three-state sequencer with round-robin grant. Misaligned and out-of-range accesses are rejected before reaching memory. The block sits directly in front of the data memory and owns its write-enable, address and write-data inputs.

## Interface
- MEM_BYTES, 1024: memory size in bytes; legal word addresses are 0 .. MEM_BYTES-4.
- I_clk  in  1  clock; all state changes on the rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_req0 / I_req1  in  1  access request from port 0 / 1; held until ack.
- I_we0 / I_we1  in  1  1 = store, 0 = load; stable while req is high.
- I_addr0 / I_addr1  in  32  byte address; stable while req is high.
- I_wdata0 / I_wdata1  in  32  store data; stable while req is high.
- O_ack0 / O_ack1  out  1  one-cycle completion pulse.
- O_err0 / O_err1  out  1  valid with ack; 1 = access rejected.
- O_rdata0 / O_rdata1  out  32  load data; valid with ack; holds value otherwise.
- O_mem_memrw  out  1  memory write enable.
- O_mem_address  out  32  memory byte address.
- O_mem_data  out  32  memory write data.
- I_mem_data  in  32  combinational read data from memory.
- O_busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - Samples I_req0 and I_req1.
  - If none is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the port opposite the last-granted pointer `last`.
  - On a grant: register the port, we, addr and wdata, plus err; go to ACCESS.
- `last` resets to 1, so port 0 wins the first tie. It updates to the granted port on every grant.
- err = (addr[1:0] != 0) OR (addr > MEM_BYTES-4), evaluated on the granted address.
- ACCESS:
  - O_mem_address = registered addr; O_mem_data = registered wdata.
  - O_mem_memrw = we & ~err & ~I_reset, combinational from the state register.
  - On the edge ending ACCESS, a load latches I_mem_data into O_rdataN of the granted port, or 0 if err. A store leaves O_rdataN unchanged.
  - Go to DONE.
- DONE:
  - O_ackN = 1 for the granted port only; O_errN = registered err.
  - Request lines are ignored in this state.
  - Go to IDLE.
- Requesters drop or change req on the edge where they sample ack. The next request is sampled in the following IDLE cycle.
- Outside ACCESS:
  - O_mem_memrw = 0.
  - O_mem_address and O_mem_data hold the last registered values (0 after reset).
- Rejected accesses never assert O_mem_memrw.

## Timing
- Reset values: O_ack0/1 = 0, O_err0/1 = 0, O_rdata0/1 = 0, O_mem_memrw = 0, O_mem_address = 0, O_mem_data = 0, O_busy = 0, state = IDLE, last = 1.
- Transaction latency: req sampled in cycle N (IDLE), ACCESS in N+1, ack in N+2. Store data is committed at the edge ending N+1.
- Throughput: one transaction per 3 cycles. A back-to-back request is sampled in N+3.
- Under continuous contention, grants alternate 0,1,0,1. A requester waits at most one foreign transaction (3 cycles) before being granted.
- Reset asserted in ACCESS:
  - The write is suppressed, because O_mem_memrw is gated by I_reset.
  - No ack is issued.
  - O_rdata is not updated.
- Reset asserted in DONE: ack is still visible that cycle; everything clears at the edge.
- A request raised during ACCESS or DONE is not lost while held. It is sampled at the next IDLE.
- Address 0xFFFFFFFC, or any address above MEM_BYTES-4, gives err = 1 with no memory access. Arithmetic is unsigned 32-bit, no wrap.

## Test plan
- Single store/load, port 0:
  - Store 0xDEADBEEF to 0x010.
  - Load 0x010.
  - Expect: O_mem_memrw high only in the ACCESS cycle of the store; ack in cycle N+2 each time; O_rdata0 = 0xDEADBEEF; O_err0 = 0.
- Simultaneous requests after reset:
  - Port 0 loads 0x000 and port 1 stores 0x11223344 to 0x004, both held high continuously.
  - Expect grant order 0,1,0,1, with acks 3 cycles apart.
- Misaligned store:
  - Port 1 stores 0xAAAAAAAA to 0x006.
  - Expect: O_ack1 with O_err1 = 1; O_mem_memrw never high; a subsequent load of 0x004 returns the old value.
- Out-of-range load:
  - Port 0 loads 0x3FD, then 0x3FC.
  - Expect: the first gives err = 1 and O_rdata0 = 0; the second gives err = 0 with memory contents.
- Reset mid-operation:
  - Assert I_reset during the ACCESS cycle of a store of 0x55AA55AA to 0x020.
  - Expect: no ack; all outputs at reset values after the edge; a later load of 0x020 returns the prior contents.
- Idle quiet:
  - No requests for 20 cycles.
  - Expect: O_busy = 0, O_mem_memrw = 0, and no acks throughout.
